// File: rtl/mc_controller_param.sv
// Mode-change controller slave for the NI schedule-table path.
// Holds a per-mode table of schedule-table window bounds, accepts a mode-change
// request over the config bus, and commits it at a TDM period boundary once the
// global phase count matches the requested phase.
module mc_controller_param #(
   parameter  int MODES      = 4,
   parameter  int STBL_IDX_W = 8,
   parameter  int MC_CNT_W   = 2,
   parameter  int ADDR_W     = 14,
   localparam int MIDX_W     = $clog2(MODES)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  run,
   input  logic [ADDR_W-1:0]     config_addr,
   input  logic                  config_en,
   input  logic                  config_wr,
   input  logic [31:0]           config_wdata,
   input  logic                  sel,
   input  logic                  period_boundary,
   input  logic [MC_CNT_W-1:0]   mc_p_cnt,
   output logic [31:0]           config_slv_rdata,
   output logic                  config_slv_error,
   output logic [STBL_IDX_W-1:0] stbl_min,
   output logic [STBL_IDX_W-1:0] stbl_maxp1,
   output logic                  mc,
   output logic [MIDX_W-1:0]     mc_idx,
   output logic [MC_CNT_W-1:0]   mc_p
);

   // Offset one past the last table entry.
   localparam logic [10:0] TBL_END = 11'(MODES + 2);

   // Architectural state
   logic [MIDX_W-1:0]     mode_idx_r;
   logic                  pending_r;
   logic [MIDX_W-1:0]     pend_idx_r;
   logic [MC_CNT_W-1:0]   pend_phase_r;
   logic [STBL_IDX_W-1:0] tbl_min_r   [MODES];
   logic [STBL_IDX_W-1:0] tbl_maxp1_r [MODES];
   logic [STBL_IDX_W-1:0] stbl_min_r;
   logic [STBL_IDX_W-1:0] stbl_maxp1_r;
   logic                  mc_r;
   logic [MIDX_W-1:0]     mc_idx_r;
   logic [MC_CNT_W-1:0]   mc_p_r;
   logic [31:0]           rdata_r;
   logic                  error_r;

   // Decode and control signals
   logic                  acc_s;
   logic [10:0]           offset_s;
   logic                  is_req_s;
   logic                  is_stat_s;
   logic                  is_tbl_s;
   logic [MIDX_W-1:0]     tbl_idx_s;
   logic                  err_s;
   logic                  req_ok_s;
   logic                  tbl_wr_s;
   logic                  rd_ok_s;
   logic [31:0]           rdata_s;
   logic                  commit_s;
   logic [MIDX_W-1:0]     next_mode_s;

   // run and the upper address/data bits carry no meaning for this slave.
   logic                  unused_s;
   assign unused_s = ^{run, config_addr, config_wdata};

   assign acc_s    = sel & config_en;
   assign offset_s = config_addr[10:0];

   // Address decode and access error classification.
   // The whole low half-word of a request is range checked so an out-of-range
   // index is rejected instead of silently aliasing onto a valid mode.
   always_comb begin
      is_req_s  = (offset_s == 11'd0);
      is_stat_s = (offset_s == 11'd1);
      is_tbl_s  = (offset_s >= 11'd2) && (offset_s < TBL_END);
      tbl_idx_s = MIDX_W'(offset_s - 11'd2);
      err_s     = 1'b0;
      if (is_req_s) begin
         if (config_wr) begin
            err_s = (config_wdata[15:0] >= 16'(MODES)) | pending_r;
         end else begin
            err_s = 1'b0;
         end
      end else if (is_stat_s) begin
         err_s = config_wr;
      end else if (is_tbl_s) begin
         err_s = 1'b0;
      end else begin
         err_s = 1'b1;
      end
   end

   assign req_ok_s = acc_s & config_wr & is_req_s & ~err_s;
   assign tbl_wr_s = acc_s & config_wr & is_tbl_s;
   assign rd_ok_s  = acc_s & ~config_wr & ~err_s;

   // Read data mux; fields are zero-extended into the 32-bit word.
   always_comb begin
      rdata_s = 32'd0;
      if (is_req_s) begin
         rdata_s[MIDX_W-1:0] = mode_idx_r;
      end else if (is_stat_s) begin
         rdata_s[31]              = pending_r;
         rdata_s[16 +: MC_CNT_W]  = pend_phase_r;
         rdata_s[MIDX_W-1:0]      = pend_idx_r;
      end else if (is_tbl_s) begin
         rdata_s[16 +: STBL_IDX_W] = tbl_maxp1_r[tbl_idx_s];
         rdata_s[STBL_IDX_W-1:0]   = tbl_min_r[tbl_idx_s];
      end else begin
         rdata_s = 32'd0;
      end
   end

   // Commit uses the pending flag from before this edge, so a request landing
   // on a boundary can only commit at a later boundary.
   assign commit_s    = pending_r & period_boundary & (mc_p_cnt == pend_phase_r);
   assign next_mode_s = commit_s ? pend_idx_r : mode_idx_r;

   // Request latching, commit and the one-cycle mode-change indication.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mode_idx_r   <= {MIDX_W{1'b0}};
         pending_r    <= 1'b0;
         pend_idx_r   <= {MIDX_W{1'b0}};
         pend_phase_r <= {MC_CNT_W{1'b0}};
         mc_r         <= 1'b0;
         mc_idx_r     <= {MIDX_W{1'b0}};
         mc_p_r       <= {MC_CNT_W{1'b0}};
      end else if (commit_s) begin
         mode_idx_r <= pend_idx_r;
         pending_r  <= 1'b0;
         mc_r       <= 1'b1;
         mc_idx_r   <= pend_idx_r;
         mc_p_r     <= pend_phase_r;
      end else begin
         mc_r     <= 1'b0;
         mc_idx_r <= {MIDX_W{1'b0}};
         mc_p_r   <= {MC_CNT_W{1'b0}};
         if (req_ok_s) begin
            pending_r    <= 1'b1;
            pend_idx_r   <= config_wdata[MIDX_W-1:0];
            pend_phase_r <= config_wdata[16 +: MC_CNT_W];
         end
      end
   end

   // Per-mode window table, written over the config bus.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < MODES; i++) begin
            tbl_min_r[i]   <= {STBL_IDX_W{1'b0}};
            tbl_maxp1_r[i] <= {STBL_IDX_W{1'b0}};
         end
      end else if (tbl_wr_s) begin
         tbl_min_r[tbl_idx_s]   <= config_wdata[STBL_IDX_W-1:0];
         tbl_maxp1_r[tbl_idx_s] <= config_wdata[16 +: STBL_IDX_W];
      end
   end

   // Active window reload at each period boundary; a same-cycle table write
   // is not visible here because the table is read before it updates.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stbl_min_r   <= {STBL_IDX_W{1'b0}};
         stbl_maxp1_r <= {STBL_IDX_W{1'b0}};
      end else if (period_boundary) begin
         stbl_min_r   <= tbl_min_r[next_mode_s];
         stbl_maxp1_r <= tbl_maxp1_r[next_mode_s];
      end
   end

   // Registered bus response: read data holds except on clean reads.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdata_r <= 32'd0;
         error_r <= 1'b0;
      end else begin
         error_r <= acc_s & err_s;
         if (rd_ok_s) begin
            rdata_r <= rdata_s;
         end
      end
   end

   assign config_slv_rdata = rdata_r;
   assign config_slv_error = error_r;
   assign stbl_min         = stbl_min_r;
   assign stbl_maxp1       = stbl_maxp1_r;
   assign mc               = mc_r;
   assign mc_idx           = mc_idx_r;
   assign mc_p             = mc_p_r;

endmodule

// File: tb/tb_mc_controller_param.sv
// Scoreboard bench for mc_controller_param (MODES=4, STBL_IDX_W=8, MC_CNT_W=2).
module tb_mc_controller_param;

   localparam int MODES      = 4;
   localparam int STBL_IDX_W = 8;
   localparam int MC_CNT_W   = 2;
   localparam int ADDR_W     = 14;
   localparam int MIDX_W     = 2;

   logic                  clk = 1'b0;
   logic                  reset = 1'b0;
   logic                  run = 1'b0;
   logic [ADDR_W-1:0]     config_addr = '0;
   logic                  config_en = 1'b0;
   logic                  config_wr = 1'b0;
   logic [31:0]           config_wdata = 32'd0;
   logic                  sel = 1'b0;
   logic                  period_boundary = 1'b0;
   logic [MC_CNT_W-1:0]   mc_p_cnt = 2'd0;
   logic [31:0]           config_slv_rdata;
   logic                  config_slv_error;
   logic [STBL_IDX_W-1:0] stbl_min;
   logic [STBL_IDX_W-1:0] stbl_maxp1;
   logic                  mc;
   logic [MIDX_W-1:0]     mc_idx;
   logic [MC_CNT_W-1:0]   mc_p;

   mc_controller_param #(
      .MODES(MODES), .STBL_IDX_W(STBL_IDX_W), .MC_CNT_W(MC_CNT_W), .ADDR_W(ADDR_W)
   ) dut (
      .clk(clk), .reset(reset), .run(run), .config_addr(config_addr),
      .config_en(config_en), .config_wr(config_wr), .config_wdata(config_wdata),
      .sel(sel), .period_boundary(period_boundary), .mc_p_cnt(mc_p_cnt),
      .config_slv_rdata(config_slv_rdata), .config_slv_error(config_slv_error),
      .stbl_min(stbl_min), .stbl_maxp1(stbl_maxp1),
      .mc(mc), .mc_idx(mc_idx), .mc_p(mc_p)
   );

   always #5 clk = ~clk;

   // Expected responses: {err, rdata}, {maxp1, min}, {mc_idx, mc_p}
   logic [32:0] cfg_q [$];
   logic [15:0] win_q [$];
   logic [3:0]  mc_q  [$];
   int          n_checks = 0;
   int          n_pass   = 0;
   logic [31:0] last_rd  = 32'd0;
   logic        acc_d    = 1'b0;
   logic        pb_d     = 1'b0;
   logic [32:0] e_cfg;
   logic [15:0] e_win;
   logic [3:0]  e_mc;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
   endtask

   task automatic unexpected(input string nm);
      n_checks++;
      $display("FAIL %s: DUT produced an output with no expectation queued", nm);
   endtask

   // Remember which cycles carried an access or a boundary.
   always @(posedge clk) begin
      acc_d <= sel & config_en;
      pb_d  <= period_boundary;
   end

   // Monitor: compare whatever the DUT presents against the scoreboard.
   always @(negedge clk) begin
      if (acc_d) begin
         if (cfg_q.size() == 0) unexpected("cfg_resp");
         else begin
            e_cfg = cfg_q.pop_front();
            chk("rdata", config_slv_rdata, e_cfg[31:0]);
            chk("error", {31'd0, config_slv_error}, {31'd0, e_cfg[32]});
         end
      end else begin
         chk("error_idle", {31'd0, config_slv_error}, 32'd0);
      end
      if (pb_d) begin
         if (win_q.size() == 0) unexpected("window");
         else begin
            e_win = win_q.pop_front();
            chk("window", {16'd0, stbl_maxp1, stbl_min}, {16'd0, e_win});
         end
      end
      if (mc === 1'b1) begin
         if (mc_q.size() == 0) unexpected("mc");
         else begin
            e_mc = mc_q.pop_front();
            chk("mc_idx_p", {28'd0, mc_idx, mc_p}, {28'd0, e_mc});
         end
      end
   end

   task automatic step(input logic en, input logic wr, input logic [10:0] off,
                       input logic [31:0] wd, input logic pb, input logic [1:0] cnt);
      sel = en; config_en = en; config_wr = wr;
      config_addr = {3'd0, off}; config_wdata = wd;
      period_boundary = pb; mc_p_cnt = cnt;
      @(negedge clk); #1;
      sel = 1'b0; config_en = 1'b0; config_wr = 1'b0; period_boundary = 1'b0;
   endtask

   task automatic rd(input logic [10:0] off, input logic [31:0] exp_val, input logic exp_err);
      if (!exp_err) last_rd = exp_val;
      cfg_q.push_back({exp_err, last_rd});
      step(1'b1, 1'b0, off, 32'd0, 1'b0, 2'd0);
   endtask

   task automatic wr(input logic [10:0] off, input logic [31:0] wd, input logic exp_err,
                     input logic pb, input logic [1:0] cnt, input logic [15:0] exp_win);
      cfg_q.push_back({exp_err, last_rd});
      if (pb) win_q.push_back(exp_win);
      step(1'b1, 1'b1, off, wd, pb, cnt);
   endtask

   task automatic bnd(input logic [1:0] cnt, input logic [15:0] exp_win);
      win_q.push_back(exp_win);
      step(1'b0, 1'b0, 11'd0, 32'd0, 1'b1, cnt);
   endtask

   task automatic chk_reset_state();
      chk("rst_rdata", config_slv_rdata, 32'd0);
      chk("rst_window", {16'd0, stbl_maxp1, stbl_min}, 32'd0);
      chk("rst_mc", {27'd0, mc, mc_idx, mc_p}, 32'd0);
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      #1;
      chk_reset_state();
      reset = 1'b1;
      @(negedge clk); #1;

      // Table programming and readback; mode 0 stays all-zero
      wr(11'd3, 32'h0020_0010, 1'b0, 1'b0, 2'd0, 16'h0000);
      rd(11'd3, 32'h0020_0010, 1'b0);
      repeat (3) bnd(2'd0, 16'h0000);

      // Request mode 1 at phase 2; non-matching phases must not commit
      wr(11'd0, 32'h0002_0001, 1'b0, 1'b0, 2'd0, 16'h0000);
      bnd(2'd0, 16'h0000);
      bnd(2'd1, 16'h0000);
      rd(11'd1, 32'h8002_0001, 1'b0);

      // Second request while pending is rejected and changes nothing
      wr(11'd0, 32'h0003_0002, 1'b1, 1'b0, 2'd0, 16'h0000);
      rd(11'd1, 32'h8002_0001, 1'b0);

      // Matching phase commits mode 1
      mc_q.push_back({2'd1, 2'd2});
      bnd(2'd2, 16'h2010);
      rd(11'd0, 32'h0000_0001, 1'b0);
      rd(11'd1, 32'h0002_0001, 1'b0);

      // Error accesses: no state change, rdata holds
      wr(11'd1, 32'h0000_0000, 1'b1, 1'b0, 2'd0, 16'h0000);
      rd(11'd6, 32'd0, 1'b1);
      wr(11'd0, 32'h0000_0005, 1'b1, 1'b0, 2'd0, 16'h0000);
      rd(11'h7FF, 32'd0, 1'b1);
      rd(11'd1, 32'h0002_0001, 1'b0);
      rd(11'd0, 32'h0000_0001, 1'b0);

      // Table write to the active entry on a boundary: old value loads first
      wr(11'd3, 32'h0040_0030, 1'b0, 1'b1, 2'd0, 16'h2010);
      bnd(2'd0, 16'h4030);
      rd(11'd3, 32'h0040_0030, 1'b0);

      // Request landing on a boundary commits only at the next boundary
      wr(11'd0, 32'h0001_0002, 1'b0, 1'b1, 2'd1, 16'h4030);
      mc_q.push_back({2'd2, 2'd1});
      bnd(2'd1, 16'h0000);
      rd(11'd0, 32'h0000_0002, 1'b0);

      // Reset while a request is pending
      wr(11'd2, 32'h0011_0022, 1'b0, 1'b0, 2'd0, 16'h0000);
      wr(11'd0, 32'h0000_0003, 1'b0, 1'b0, 2'd0, 16'h0000);
      bnd(2'd1, 16'h0000);
      rd(11'd1, 32'h8000_0003, 1'b0);
      reset = 1'b0;
      @(negedge clk); #1;
      chk_reset_state();
      reset = 1'b1;
      last_rd = 32'd0;
      @(negedge clk); #1;
      rd(11'd1, 32'h0000_0000, 1'b0);
      bnd(2'd0, 16'h0000);
      bnd(2'd0, 16'h0000);
      rd(11'd0, 32'h0000_0000, 1'b0);
      rd(11'd2, 32'h0000_0000, 1'b0);

      // Drain and confirm every expectation was consumed
      repeat (3) @(negedge clk);
      #1;
      chk("cfg_q_drained", cfg_q.size(), 32'd0);
      chk("win_q_drained", win_q.size(), 32'd0);
      chk("mc_q_drained", mc_q.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
